data_store_buffer: RTL
======================

Name: data_store_buffer

Overview:
- Sits between the core's data-SRAM port (EX-stage request, MEM-stage read data) and the physical data SRAM.
- Posts stores into a small in-order FIFO so that stores complete without waiting for the SRAM.
- Drains buffered stores to the SRAM only when the port is idle, or when the core must be stalled.
- Raises a stall request toward the pipeline controller, alongside the ID and EX stall requests.

Parameters:
DEPTH, 4, number of store entries; must be a power of two, at least 2
PTR_W, $clog2(DEPTH), localparam; FIFO pointer width

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
cpu_en  input  1  core data request valid (EX stage)
cpu_wen  input  4  byte write enables; 0 means load
cpu_addr  input  32  byte address
cpu_wdata  input  32  store data, already byte-lane aligned
cpu_rdata  output  32  load data returned to the MEM stage
stallreq_from_sb  output  1  pipeline stall request to CTRL (combinational)
sram_en  output  1  SRAM enable
sram_wen  output  4  SRAM byte write enables
sram_addr  output  32  SRAM address
sram_wdata  output  32  SRAM write data
sram_rdata  input  32  SRAM read data, valid the cycle after a read enable
sb_count  output  PTR_W+1  current number of valid entries (debug/verification)

Behaviour:
- Entry fields: word address (addr[31:2]), wen[3:0], wdata[31:0]. Storage is circular, with head pointer, tail pointer and count.
- Reset (synchronous): head=0, tail=0, count=0. Entry storage is not cleared. During reset cycles: sram_en=0, sram_wen=0, stallreq_from_sb=0.
- Request classes this cycle:
  - store = cpu_en & |cpu_wen
  - load = cpu_en & ~|cpu_wen
  - idle = ~cpu_en
- full = (count==DEPTH), using the registered count only; a same-cycle drain does not un-full.
- hit = load and any valid entry has word address == cpu_addr[31:2].
- stallreq_from_sb = (store & full) | (load & hit). It is combinational, in the same cycle as the request.
- drain = (count>0) & (idle | stallreq_from_sb).
- SRAM port priority, one access per cycle:
  1. load & ~hit: sram_en=1, sram_wen=0, sram_addr=cpu_addr; no drain this cycle.
  2. drain: sram_en=1, sram_wen=head.wen, sram_addr={head.addr,2'b00}, sram_wdata=head.wdata; head++ and count-- at the clock edge.
  3. otherwise: sram_en=0, sram_wen=0.
- Store acceptance: store & ~full enqueues {cpu_addr[31:2], cpu_wen, cpu_wdata} at tail; tail++ and count++. The SRAM is not accessed for the store itself.
- A stalled store or stalled load is not recorded. The core holds the request and it is re-evaluated on the next cycle.
- Simultaneous enqueue and drain is impossible by construction: a drain needs idle or a stall, and a stall means no enqueue.
- Stores to the same word are kept as separate entries. FIFO order guarantees last-writer-wins in the SRAM.
- Pointer wrap: both pointers increment modulo DEPTH (natural PTR_W-bit overflow).
- cpu_rdata = sram_rdata, a direct passthrough. Load latency is unchanged: one cycle from the EX request to MEM data.
- A load hit stalls repeatedly while the buffer drains in order. It proceeds on the first cycle with no matching entry, which can be before the buffer is empty.
- rst asserted mid-drain: the in-flight SRAM write of that cycle is suppressed (sram_en=0 while rst), and all buffered stores are discarded.

Decomposition:
- Shared defines header gains:
  - `SB_DEPTH default
  - entry-width constant `SB_ENTRY_WD = 30+4+32 = 66
  - bus-width constant for the CPU-side request bundle, if it is bundled like other stage buses
- One sub-module, sb_fifo: circular storage with push/pop, head read-out, count/full/empty, and a parallel word-address compare output (DEPTH match bits qualified by valid).
- The top level holds the classification, the stall logic and the SRAM mux only.

Test Plan:
- Reset → sb_count=0, stallreq_from_sb=0, sram_en=0. Then idle cycles → sram_en stays 0.
- Store addr 0x100, wen=4'hF, data 0xDEADBEEF, then idle → store cycle has sram_en=0 and count becomes 1. Next cycle: sram_en=1, wen=4'hF, addr=0x100, wdata=0xDEADBEEF, and count becomes 0.
- Four back-to-back stores to 0x0/0x4/0x8/0xC, then a 5th store to 0x10 held for 2 cycles →
  - 5th store, cycle 1: stallreq=1 and the drain writes 0x0
  - 5th store, cycle 2: stallreq=0, the store is accepted, count=4
  - the 5th store is last in drain order
- Store 0x200 (wen=4'b0011, data 0x0000BEEF), then load 0x202 → load cycle: stallreq=1, drain writes 0x200. Next cycle: stallreq=0, sram_en=1, wen=0, addr=0x202.
- Store 0x300, then load 0x400 → load goes to SRAM immediately, stallreq=0, count stays 1. Next-cycle cpu_rdata equals sram_rdata. The store drains on the following idle cycle.
- Fill to count=3 with the head drain in progress, then assert rst for one cycle → sram_en=0 during rst, count=0 afterwards, and no further SRAM writes on subsequent idle cycles.

Source files
------------

// File: rtl/data_store_buffer_pkg.sv
// Shared types and sizing for the data-side store buffer.
// Entries hold a word address, byte enables and lane-aligned data.
package data_store_buffer_pkg;

    localparam int SB_DEPTH    = 4;
    localparam int SB_ENTRY_WD = 30 + 4 + 32;
    localparam int SB_REQ_WD   = 1 + 4 + 32 + 32;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } sb_entry_t;

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sb_req_t;

endpackage

// File: rtl/data_store_buffer_sb_fifo.sv
// Circular store FIFO with head read-out and a parallel
// word-address compare across all valid entries.
module sb_fifo
    import data_store_buffer_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    input  logic [29:0]      match_addr,
    output sb_entry_t        head_entry,
    output logic [DEPTH-1:0] match,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    sb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] off;
    logic [DEPTH-1:0] valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is deliberately not reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_entry;
    end

    always_comb begin
        off   = '0;
        valid = '0;
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PTR_W'(i) - head;
            valid[i] = {1'b0, off} < count;
            match[i] = valid[i] & (mem[i].addr == match_addr);
        end
    end

    assign head_entry = mem[head];
    assign full       = count == (PTR_W + 1)'(DEPTH);
    assign empty      = count == '0;

endmodule

// File: rtl/data_store_buffer.sv
// Store buffer between the core data port and the data SRAM:
// posts stores, drains them when the port is idle or stalled.
module data_store_buffer
    import data_store_buffer_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_en,
    input  logic [3:0]       cpu_wen,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             stallreq_from_sb,
    output logic             sram_en,
    output logic [3:0]       sram_wen,
    output logic [31:0]      sram_addr,
    output logic [31:0]      sram_wdata,
    input  logic [31:0]      sram_rdata,
    output logic [PTR_W:0]   sb_count
);

    sb_req_t          req;
    sb_entry_t        new_entry;
    sb_entry_t        head_entry;
    logic [DEPTH-1:0] match;
    logic             store;
    logic             load;
    logic             idle;
    logic             hit;
    logic             full;
    logic             empty;
    logic             drain;
    logic             push;

    assign req = '{en: cpu_en, wen: cpu_wen, addr: cpu_addr, wdata: cpu_wdata};

    assign store = req.en & (|req.wen);
    assign load  = req.en & ~(|req.wen);
    assign idle  = ~req.en;
    assign hit   = load & (|match);

    assign stallreq_from_sb = ~rst & ((store & full) | (load & hit));

    // A drain only happens on idle or stall, so it never meets a push.
    assign drain = ~rst & ~empty & (idle | stallreq_from_sb);
    assign push  = ~rst & store & ~full;

    assign new_entry = '{addr: req.addr[31:2], wen: req.wen, wdata: req.wdata};

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (new_entry),
        .pop        (drain),
        .match_addr (req.addr[31:2]),
        .head_entry (head_entry),
        .match      (match),
        .count      (sb_count),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'h0;
        sram_addr  = '0;
        sram_wdata = '0;
        priority case (1'b1)
            rst: ;
            load & ~hit: begin
                sram_en   = 1'b1;
                sram_addr = req.addr;
            end
            drain: begin
                sram_en    = 1'b1;
                sram_wen   = head_entry.wen;
                sram_addr  = {head_entry.addr, 2'b00};
                sram_wdata = head_entry.wdata;
            end
            default: ;
        endcase
    end

    assign cpu_rdata = sram_rdata;

endmodule
